// File: rtl/noc_pkg.sv
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC router definitions: direction indices, default
//                flit width, output-port controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

  localparam int DIR_S = 3;
  localparam int DIR_W = 2;
  localparam int DIR_E = 1;
  localparam int DIR_L = 0;

  localparam int NOC_FLIT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } opc_state_t;

  // True when exactly one of the four grant bits is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/n_output_port_ctrl_credit_counter.sv
// ============================================================================
//  Module      : credit_counter
//  Description : Downstream credit counter; saturates at CREDITS, a send and
//                a return in the same cycle cancel out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_counter
  import noc_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec,
  input  logic                           inc,
  output logic [$clog2(CREDITS+1)-1:0]   cnt,
  output logic                           nonzero
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(CREDITS);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= C_MAX;
    end else if (dec && !inc) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end else if (inc && !dec) begin
      if (r_cnt != C_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt     = r_cnt;
  assign nonzero = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/n_output_port_ctrl.sv
// ============================================================================
//  Module      : n_output_port_ctrl
//  Description : North output-port controller: locks the crossbar to the
//                round-robin winner for one packet, forwards flits under
//                credit flow control, pulses change-order after the tail.
//                Optional idle-owner watchdog: define OPC_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n_output_port_ctrl
  import noc_pkg::*;
#(
  parameter int FLIT_W  = NOC_FLIT_W,
  parameter int CREDITS = 4
`ifdef OPC_WATCHDOG_EN
  ,
  parameter int WDOG_LIMIT = 255
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          rrp_grant_i,
  input  logic                rrp_grant_valid_i,
  input  logic [4*FLIT_W-1:0] in_flit_i,
  input  logic [3:0]          in_valid_i,
  input  logic [3:0]          in_tail_i,
  output logic [3:0]          in_ready_o,
  output logic [FLIT_W-1:0]   out_flit_o,
  output logic                out_valid_o,
  output logic                out_tail_o,
  input  logic                credit_return_i,
  output logic                rr_change_order_o,
  output logic [3:0]          xbar_sel_o,
`ifdef OPC_WATCHDOG_EN
  output logic                wdog_err_o,
`endif
  output logic                port_busy_o
);

  localparam int CNT_W = $clog2(CREDITS + 1);

  opc_state_t        r_state;
  logic [3:0]        r_owner;
  logic              r_change_order;
  logic              r_busy;
  logic [FLIT_W-1:0] r_out_flit;
  logic              r_out_valid;
  logic              r_out_tail;

  logic [CNT_W-1:0]  w_credit_cnt;
  logic              w_credit_nz;
  logic [FLIT_W-1:0] w_sel_flit;
  logic              w_sel_valid;
  logic              w_sel_tail;
  logic              w_xfer;
  logic              w_wdog_hit;

  // Owner-driven input mux; owner is one-hot so OR-merging is safe.
  always_comb begin
    w_sel_flit  = '0;
    w_sel_valid = 1'b0;
    w_sel_tail  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (r_owner[i]) begin
        w_sel_flit  = w_sel_flit | in_flit_i[i*FLIT_W +: FLIT_W];
        w_sel_valid = w_sel_valid | in_valid_i[i];
        w_sel_tail  = w_sel_tail | in_tail_i[i];
      end
    end
  end

  assign w_xfer     = (r_state == ACTIVE) && w_sel_valid && w_credit_nz;
  assign in_ready_o = ((r_state == ACTIVE) && w_credit_nz) ? r_owner : 4'b0000;

  credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk     (clk),
    .reset   (reset),
    .dec     (w_xfer),
    .inc     (credit_return_i),
    .cnt     (w_credit_cnt),
    .nonzero (w_credit_nz)
  );

`ifdef OPC_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] r_wdog_cnt;
  logic            r_wdog_err;
  logic            w_wdog_idle;

  // Owner is stalled either by missing data or by missing downstream credit.
  assign w_wdog_idle = (r_state == ACTIVE) && (!w_sel_valid || !w_credit_nz);
  assign w_wdog_hit  = w_wdog_idle && (r_wdog_cnt == WD_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state != ACTIVE || w_xfer) begin
        r_wdog_cnt <= '0;
      end else if (w_wdog_idle && !w_wdog_hit) begin
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
      if (w_wdog_hit) r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err_o = r_wdog_err;
`else
  assign w_wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_owner        <= 4'b0000;
      r_change_order <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_change_order <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rrp_grant_valid_i && is_onehot4(rrp_grant_i)) begin
            r_state <= ACTIVE;
            r_owner <= rrp_grant_i;
            r_busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          if ((w_xfer && w_sel_tail) || w_wdog_hit) begin
            r_state        <= RELEASE;
            r_change_order <= 1'b1;
          end
        end
        RELEASE: begin
          // Grant seen this cycle predates the rotation, so it is dropped.
          r_state <= IDLE;
          r_owner <= 4'b0000;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_owner <= 4'b0000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
      r_out_tail  <= 1'b0;
    end else begin
      r_out_valid <= w_xfer;
      r_out_tail  <= w_xfer && w_sel_tail;
      if (w_xfer) r_out_flit <= w_sel_flit;
    end
  end

  assign out_flit_o        = r_out_flit;
  assign out_valid_o       = r_out_valid;
  assign out_tail_o        = r_out_tail;
  assign rr_change_order_o = r_change_order;
  assign xbar_sel_o        = r_owner;
  assign port_busy_o       = r_busy;

endmodule

`default_nettype wire
